// File: rtl/ssd_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl_if: data/control bundle between a host and the display scanner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ssd_scan_ctrl_if #(
  parameter int N        = 4,
  parameter int BRIGHT_W = 4
);
  logic [N*4-1:0]      numbers;
  logic [N-1:0]        dp;
  logic [N-1:0]        blank;
  logic                load;
  logic [BRIGHT_W-1:0] brightness;
  logic                lz_suppress;
  logic [N-1:0]        displays;
  logic [6:0]          segments;
  logic                dp_out;
  logic                frame_done;

  modport master (
    output numbers, dp, blank, load, brightness, lz_suppress,
    input  displays, segments, dp_out, frame_done
  );

  modport slave (
    input  numbers, dp, blank, load, brightness, lz_suppress,
    output displays, segments, dp_out, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl: double-buffered multiplexed 7-segment scanner with PWM dimming
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ssd_scan_ctrl #(
  parameter int N        = 4,
  parameter int CLK_DIV  = 1024,
  parameter int BRIGHT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  ssd_scan_ctrl_if.slave   bus
);

  localparam int PW  = $clog2(CLK_DIV);
  localparam int DW  = (N > 1) ? $clog2(N) : 1;
  localparam int SUB = CLK_DIV >> BRIGHT_W;

  localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIG_MAX  = DW'(N - 1);
  localparam logic [PW-1:0] SUB_LEN  = PW'(SUB);

  logic [PW-1:0]  pcnt;
  logic [DW-1:0]  dig;
  logic           pending;
  logic [N*4-1:0] shadow_num;
  logic [N-1:0]   shadow_dp;
  logic [N-1:0]   shadow_blank;
  logic [N*4-1:0] active_num;
  logic [N-1:0]   active_dp;
  logic [N-1:0]   active_blank;

  logic           slot_end;
  logic           frame_end;
  logic [3:0]     cur_digit;
  logic [PW-1:0]  sub_idx;
  logic           pwm_on;
  logic [N-1:0]   zero_from;
  logic           suppressed;
  logic [N-1:0]   displays_d;
  logic [6:0]     segments_d;
  logic           dp_d;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  assign slot_end  = (pcnt == PCNT_MAX);
  assign frame_end = slot_end && (dig == DIG_MAX);

  // Slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      dig  <= '0;
    end else if (slot_end) begin
      pcnt <= '0;
      dig  <= (dig == DIG_MAX) ? '0 : dig + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Shadow/active buffers; a load on the frame boundary bypasses the shadow
  // stage so it lands in the very frame that starts next.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= 1'b0;
      shadow_num   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      active_num   <= '0;
      active_dp    <= '0;
      active_blank <= '1;
    end else begin
      if (bus.load) begin
        shadow_num   <= bus.numbers;
        shadow_dp    <= bus.dp;
        shadow_blank <= bus.blank;
      end
      if (frame_end) begin
        if (bus.load) begin
          active_num   <= bus.numbers;
          active_dp    <= bus.dp;
          active_blank <= bus.blank;
        end else if (pending) begin
          active_num   <= shadow_num;
          active_dp    <= shadow_dp;
          active_blank <= shadow_blank;
        end
        pending <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  // zero_from[i] is set when active digits i..N-1 are all zero
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    for (int i = N - 1; i >= 0; i--) begin
      acc          = acc && (active_num[i*4 +: 4] == 4'h0);
      zero_from[i] = acc;
    end
  end

  assign cur_digit  = active_num[dig*4 +: 4];
  assign sub_idx    = pcnt / SUB_LEN;
  assign pwm_on     = (sub_idx <= PW'(bus.brightness));
  assign suppressed = bus.lz_suppress && (dig != '0) && zero_from[dig];

  always_comb begin
    displays_d = '1;
    segments_d = 7'h7F;
    dp_d       = 1'b1;
    if (pwm_on && !active_blank[dig]) begin
      if (!suppressed) begin
        displays_d = ~(N'(1) << dig);
        segments_d = seg7(cur_digit);
        dp_d       = ~active_dp[dig];
      end else if (active_dp[dig]) begin
        // Suppressed zero still lights its decimal point
        displays_d = ~(N'(1) << dig);
        dp_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.displays   <= '1;
      bus.segments   <= 7'h7F;
      bus.dp_out     <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.displays   <= displays_d;
      bus.segments   <= segments_d;
      bus.dp_out     <= dp_d;
      bus.frame_done <= frame_end;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_ctrl: scoreboard bench for ssd_scan_ctrl (N=4, CLK_DIV=32, BRIGHT_W=2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ssd_scan_ctrl;
  localparam int N        = 4;
  localparam int CLK_DIV  = 32;
  localparam int BRIGHT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssd_scan_ctrl_if #(.N(N), .BRIGHT_W(BRIGHT_W)) bus ();

  ssd_scan_ctrl #(.N(N), .CLK_DIV(CLK_DIV), .BRIGHT_W(BRIGHT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // tick = number of rising edges since the first (reset) edge, which is tick 0
  int tick = -1;
  always @(posedge clk) tick <= tick + 1;

  typedef struct {
    int         at;
    string      name;
    logic [3:0] disp;
    logic [6:0] seg;
    logic       dpo;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input int at, input string nm, input logic [3:0] d,
                      input logic [6:0] s, input logic dpo, input logic fd);
    exp_t e;
    e.at = at; e.name = nm; e.disp = d; e.seg = s; e.dpo = dpo; e.fd = fd;
    q.push_back(e);
  endtask

  task automatic push_dark(input int at, input string nm, input logic fd);
    push(at, nm, 4'hF, 7'h7F, 1'b1, fd);
  endtask

  task automatic wait_state(input int t);
    while (tick < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int t, input logic [15:0] num,
                         input logic [3:0] d, input logic [3:0] b);
    wait_state(t);
    bus.numbers = num;
    bus.dp      = d;
    bus.blank   = b;
    bus.load    = 1'b1;
    wait_state(t + 1);
    bus.load    = 1'b0;
  endtask

  // Monitor: outputs are sampled on the falling edge of each cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= tick) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.at < tick) begin
        failures++;
        $display("FAIL %s missed sample at tick %0d (now %0d)", e.name, e.at, tick);
      end else if ({bus.displays, bus.segments, bus.dp_out, bus.frame_done} !==
                   {e.disp, e.seg, e.dpo, e.fd}) begin
        failures++;
        $display("FAIL %s tick=%0d actual disp=%h seg=%h dp_out=%b fd=%b required disp=%h seg=%h dp_out=%b fd=%b",
                 e.name, tick, bus.displays, bus.segments, bus.dp_out, bus.frame_done,
                 e.disp, e.seg, e.dpo, e.fd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at tick %0d", tick);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.numbers     = '0;
    bus.dp          = '0;
    bus.blank       = '0;
    bus.load        = 1'b0;
    bus.brightness  = 2'd3;
    bus.lz_suppress = 1'b0;

    // Reset state and first frame of 1234
    push_dark(0,   "reset_outputs", 1'b0);
    push_dark(5,   "dark_before_load", 1'b0);
    push_dark(128, "frame0_done", 1'b1);
    push(129, "f1_dig0", 4'hE, 7'h4C, 1'b1, 1'b0);
    push(169, "f1_dig1", 4'hD, 7'h06, 1'b1, 1'b0);
    push(224, "f1_dig2", 4'hB, 7'h12, 1'b1, 1'b0);
    push(241, "f1_dig3", 4'h7, 7'h4F, 1'b1, 1'b0);
    push(256, "f1_done", 4'h7, 7'h4F, 1'b1, 1'b1);
    wait_state(0);
    rst = 1'b0;
    do_load(1, 16'h1234, 4'b0000, 4'b0000);

    // Brightness 1 applied live, then 0008 for the next frame
    wait_state(300);
    bus.brightness = 2'd1;
    push(301, "bright1_s1_on", 4'hD, 7'h06, 1'b1, 1'b0);
    push_dark(309, "bright1_s2_off", 1'b0);
    push_dark(383, "f2_last_off", 1'b0);
    push_dark(384, "f2_done", 1'b1);
    push(385, "b1_dig0_start", 4'hE, 7'h00, 1'b1, 1'b0);
    push(400, "b1_dig0_p15", 4'hE, 7'h00, 1'b1, 1'b0);
    push_dark(401, "b1_dig0_p16", 1'b0);
    push_dark(416, "b1_dig0_p31", 1'b0);
    push(417, "b1_dig1_zero", 4'hD, 7'h01, 1'b1, 1'b0);
    do_load(300, 16'h0008, 4'b0000, 4'b0000);

    wait_state(448);
    bus.brightness = 2'd0;
    push(449, "b0_p0", 4'hB, 7'h01, 1'b1, 1'b0);
    push(456, "b0_p7", 4'hB, 7'h01, 1'b1, 1'b0);
    push_dark(457, "b0_p8", 1'b0);

    // Leading-zero suppression with dp on a suppressed digit
    wait_state(500);
    bus.brightness  = 2'd3;
    bus.lz_suppress = 1'b1;
    push(518, "lz_dig0", 4'hE, 7'h01, 1'b1, 1'b0);
    push(550, "lz_dig1", 4'hD, 7'h0F, 1'b1, 1'b0);
    push(590, "lz_dig2_dp", 4'hB, 7'h7F, 1'b0, 1'b0);
    push_dark(620, "lz_dig3", 1'b0);
    do_load(500, 16'h0070, 4'b0100, 4'b0000);

    push(650, "lz0_dig0", 4'hE, 7'h01, 1'b1, 1'b0);
    push_dark(680, "lz0_dig1", 1'b0);
    push_dark(710, "lz0_dig2", 1'b0);
    push_dark(745, "lz0_dig3", 1'b0);
    do_load(520, 16'h0000, 4'b0000, 4'b0000);

    // Two loads in one frame: only the last shows, and only next frame
    push_dark(760, "no_tear", 1'b0);
    push(780, "bb_dig0", 4'hE, 7'h60, 1'b1, 1'b0);
    push_dark(810, "bb_dig1_forced_blank", 1'b0);
    push(850, "bb_dig2", 4'hB, 7'h60, 1'b1, 1'b0);
    push(880, "bb_dig3", 4'h7, 7'h60, 1'b1, 1'b0);
    push(896, "bb_done", 4'h7, 7'h60, 1'b1, 1'b1);
    do_load(650, 16'hAAAA, 4'b0000, 4'b0000);
    do_load(660, 16'hBBBB, 4'b0010, 4'b0010);

    // Load on the boundary cycle takes effect immediately
    push(897, "bnd_load_dig0", 4'hE, 7'h31, 1'b0, 1'b0);
    push(1024, "cc_done", 4'h7, 7'h31, 1'b1, 1'b1);
    push(1030, "cc_next_frame", 4'hE, 7'h31, 1'b0, 1'b0);
    do_load(895, 16'hCCCC, 4'b0001, 4'b0000);

    // Reset mid-slot discards the pending load
    push(1050, "pre_rst", 4'hE, 7'h31, 1'b0, 1'b0);
    push_dark(1051, "post_rst_dark", 1'b0);
    push_dark(1179, "post_rst_frame_done", 1'b1);
    push_dark(1185, "pending_lost", 1'b0);
    do_load(1040, 16'hDDDD, 4'b0000, 4'b0000);
    wait_state(1050);
    rst = 1'b1;
    wait_state(1051);
    rst = 1'b0;

    push_dark(1307, "recover_done", 1'b1);
    push(1308, "recover_dig0", 4'hE, 7'h04, 1'b1, 1'b0);
    push_dark(1340, "recover_dig1_lz", 1'b0);
    do_load(1190, 16'h0009, 4'b0000, 4'b0000);

    wait_state(1360);
    @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s never sampled (due tick %0d)", e.name, e.at);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
